cipher_round_ctrl_scan: RTL

Parametrised round-sequencing controller for iterative block-cipher datapaths (DES and similar Feistel cores). It sequences load, per-round iteration and output capture for a configurable round count, and supports encrypt/decrypt key-index ordering, abort and back-to-back restart. Every state-holding register sits on a serial scan chain for test access. It sits between the SPI command layer and the cipher datapath, driving the datapath's L/R register and output register enables.

---
 rtl/cipher_ctrl_pkg.sv | 13 +
 rtl/scan_register_ar.sv | 35 +++
 rtl/cipher_round_ctrl_scan.sv | 123 ++++++++++++
 3 files changed

// File: rtl/cipher_ctrl_pkg.sv
// Shared definitions for the cipher round controller: state encoding and widths.
package cipher_ctrl_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ROUND = 2'd2,
        LAST  = 2'd3
    } state_e;

endpackage

// File: rtl/scan_register_ar.sv
// Register segment with async active-low reset, sync clear, enable and scan shift.
// Shift enters at bit 0 and leaves from the MSB.
module scan_register_ar #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scan_enable,
    input  logic             scan_in,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             scan_out
);

    logic [WIDTH-1:0] shifted;

    // Concatenate then truncate so the WIDTH=1 case needs no special slice.
    assign shifted  = WIDTH'({q, scan_in});
    assign scan_out = q[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (scan_enable) begin
            q <= shifted;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/cipher_round_ctrl_scan.sv
// Round-sequencing controller for iterative Feistel datapaths with optional scan chain.
// Scan chain built only when CIPHER_ROUND_CTRL_SCAN_EN is defined.
module cipher_round_ctrl_scan
    import cipher_ctrl_pkg::*;
#(
    parameter  int unsigned ROUNDS = 16,
    localparam int unsigned CNT_W  = $clog2(ROUNDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode_decrypt,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] round,
    output logic [CNT_W-1:0] key_idx,
    output logic             ld_l_r,
    output logic             sel_l_r,
    output logic             ld_output,
    input  logic             scan_enable,
    input  logic             scan_in,
    output logic             scan_out
);

    localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(ROUNDS - 2);
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(ROUNDS - 1);

    logic               scan_en_int;
    logic               scan_in_int;
    state_e             state_q;
    state_e             state_d;
    logic [STATE_W-1:0] state_bits_q;
    logic [STATE_W-1:0] state_bits_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               cnt_clr;
    logic               cnt_en;
    logic               mode_en;
    logic               mode_q;
    logic               done_q;
    logic               done_d;
    logic               cnt_so;
    logic               state_so;
    logic               mode_so;
    logic               done_so;

`ifdef CIPHER_ROUND_CTRL_SCAN_EN
    assign scan_en_int = scan_enable;
    assign scan_in_int = scan_in;
    assign scan_out    = done_so;
`else
    logic unused_scan;
    assign scan_en_int = 1'b0;
    assign scan_in_int = 1'b0;
    assign scan_out    = 1'b0;
    assign unused_scan = ^{scan_enable, scan_in, done_so};
`endif

    // Next state and register controls
    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        mode_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) state_d = LOAD;
            end
            LOAD: begin
                cnt_clr = 1'b1;
                mode_en = 1'b1;
                state_d = abort ? IDLE : ROUND;
            end
            ROUND: begin
                cnt_en = 1'b1;
                if (abort)                      state_d = IDLE;
                else if (cnt_q == CNT_PRE_LAST) state_d = LAST;
            end
            LAST: begin
                state_d = start ? LOAD : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign state_bits_d = STATE_W'(state_d);
    assign state_q      = state_e'(state_bits_q);
    assign cnt_d        = cnt_q + CNT_W'(1);
    assign done_d       = (state_q == LAST);

    // Chain: scan_in -> counter -> state -> mode -> done_reg -> scan_out
    scan_register_ar #(.WIDTH(CNT_W)) u_cnt (
        .clk(clk), .rst_n(rst_n), .scan_enable(scan_en_int), .scan_in(scan_in_int),
        .clr(cnt_clr), .en(cnt_en), .d(cnt_d), .q(cnt_q), .scan_out(cnt_so)
    );

    scan_register_ar #(.WIDTH(STATE_W)) u_state (
        .clk(clk), .rst_n(rst_n), .scan_enable(scan_en_int), .scan_in(cnt_so),
        .clr(1'b0), .en(1'b1), .d(state_bits_d), .q(state_bits_q), .scan_out(state_so)
    );

    scan_register_ar #(.WIDTH(1)) u_mode (
        .clk(clk), .rst_n(rst_n), .scan_enable(scan_en_int), .scan_in(state_so),
        .clr(1'b0), .en(mode_en), .d(mode_decrypt), .q(mode_q), .scan_out(mode_so)
    );

    scan_register_ar #(.WIDTH(1)) u_done (
        .clk(clk), .rst_n(rst_n), .scan_enable(scan_en_int), .scan_in(mode_so),
        .clr(1'b0), .en(1'b1), .d(done_d), .q(done_q), .scan_out(done_so)
    );

    // Enables decode straight from the state register and are gated off while shifting
    assign busy      = (state_q != IDLE) & ~scan_en_int;
    assign ld_l_r    = ((state_q == LOAD) | (state_q == ROUND)) & ~scan_en_int;
    assign sel_l_r   = (state_q == ROUND) & ~scan_en_int;
    assign ld_output = (state_q == LAST) & ~scan_en_int;
    assign done      = done_q & ~scan_en_int;

    assign round   = cnt_q;
    assign key_idx = mode_q ? (CNT_LAST - cnt_q) : cnt_q;

endmodule
